// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: elastic EX/MEM pipeline register with optional two-entry skid buffer
// Ports: Clk, Reset_n (async, active-low); EX side In_Valid/In_Ready/In_Ctrl/In_Data;
//   MEM side Out_Valid/Out_Ready/Out_Ctrl/Out_Data; Flush squashes every held and incoming
//   entry; Occupancy reports entries held (0..2).
module ex_mem_pipe_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int SKID = 1,
  parameter int CLEAR_DATA = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  input  logic              Flush,
  output logic [1:0]        Occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic valid_q, rdy_q, accept, issue, load_main, load_skid, pop_skid, clr_data;
  // Without the skid entry, ready must see MEM's ready in the same cycle to avoid a bubble.
  assign In_Ready = (SKID != 0) ? rdy_q : (!valid_q | Out_Ready);
  assign accept = In_Valid & In_Ready;
  assign issue = valid_q & Out_Ready;
  assign Out_Valid = valid_q;
  assign Out_Ctrl = valid_q ? main_ctrl : '0;
  assign Out_Data = main_data;
  assign Occupancy = state_q;
  assign clr_data = (CLEAR_DATA != 0) && (state_d == EMPTY);
  always_comb begin
    state_d = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid = 1'b0;
    if (Flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: begin
          load_main = accept;
          state_d = accept ? ONE : EMPTY;
        end
        ONE: begin
          load_main = accept & issue;
          load_skid = accept & !issue;
          state_d = (accept & !issue) ? TWO : (!accept & issue) ? EMPTY : ONE;
        end
        TWO: begin
          pop_skid = issue;
          state_d = issue ? ONE : TWO;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      rdy_q <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= state_d != EMPTY;
      rdy_q <= state_d != TWO;
      if (load_main) begin
        main_ctrl <= In_Ctrl;
        main_data <= In_Data;
      end else if (pop_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (clr_data) main_data <= '0;
      if (load_skid) begin
        skid_ctrl <= In_Ctrl;
        skid_data <= In_Data;
      end
    end
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: checks three ex_mem_pipe_reg variants (skid, no-skid, skid+clear) against a FIFO model
module tb_ex_mem_pipe_reg;
  localparam int CW = 16;
  localparam int DW = 32;
  logic Clk = 1'b0, Reset_n = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b0, Flush = 1'b0;
  logic [CW-1:0] In_Ctrl = '0;
  logic [DW-1:0] In_Data = '0;
  logic ov[3], ir[3];
  logic [CW-1:0] oc[3];
  logic [DW-1:0] od[3];
  logic [1:0] occ[3];
  int checks = 0, failures = 0;
  logic [CW-1:0] mc[3][2];
  logic [DW-1:0] md[3][2];
  logic [DW-1:0] last[3];
  int cnt[3];
  bit mr[3];
  typedef struct {
    logic v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic r, f, ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [1:0] eocc;
    logic eir;
  } vec_t;
  vec_t tbl[13];
  always #5 Clk = ~Clk;
  ex_mem_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(0)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(ir[0]), .In_Ctrl(In_Ctrl),
    .In_Data(In_Data), .Out_Valid(ov[0]), .Out_Ready(Out_Ready), .Out_Ctrl(oc[0]),
    .Out_Data(od[0]), .Flush(Flush), .Occupancy(occ[0]));
  ex_mem_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(ir[1]), .In_Ctrl(In_Ctrl),
    .In_Data(In_Data), .Out_Valid(ov[1]), .Out_Ready(Out_Ready), .Out_Ctrl(oc[1]),
    .Out_Data(od[1]), .Flush(Flush), .Occupancy(occ[1]));
  ex_mem_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1)) dut_c (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(ir[2]), .In_Ctrl(In_Ctrl),
    .In_Data(In_Data), .Out_Valid(ov[2]), .Out_Ready(Out_Ready), .Out_Ctrl(oc[2]),
    .Out_Data(od[2]), .Flush(Flush), .Occupancy(occ[2]));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      cnt[m] = 0;
      mr[m] = 1'b0;
      last[m] = '0;
    end
  endtask
  // Instance 1 has no skid entry, instance 2 zeroes its payload when empty.
  task automatic model_update();
    bit r, acc, iss;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 3; m++) begin
      r = (m != 1) ? mr[m] : (cnt[m] == 0 || Out_Ready);
      acc = In_Valid && r;
      iss = cnt[m] > 0 && Out_Ready;
      if (Flush) begin
        cnt[m] = 0;
        if (m == 2) last[m] = '0;
      end else begin
        if (iss) begin
          mc[m][0] = mc[m][1];
          md[m][0] = md[m][1];
          cnt[m]--;
        end
        if (acc) begin
          mc[m][cnt[m]] = In_Ctrl;
          md[m][cnt[m]] = In_Data;
          cnt[m]++;
        end
        if (cnt[m] > 0) last[m] = md[m][0];
        else if (m == 2) last[m] = '0;
      end
      mr[m] = cnt[m] < 2;
    end
  endtask
  task automatic check_model();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("m%0d_valid", m), 64'(ov[m]), 64'(cnt[m] > 0));
      chk($sformatf("m%0d_ctrl", m), 64'(oc[m]), 64'(cnt[m] > 0 ? mc[m][0] : '0));
      chk($sformatf("m%0d_data", m), 64'(od[m]), 64'(last[m]));
      chk($sformatf("m%0d_occ", m), 64'(occ[m]), 64'(cnt[m]));
      chk($sformatf("m%0d_inrdy", m), 64'(ir[m]), 64'((m != 1) ? mr[m] : (cnt[m] == 0 || Out_Ready)));
    end
  endtask
  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r, input logic f);
    @(negedge Clk);
    In_Valid = v;
    In_Ctrl = c;
    In_Data = d;
    Out_Ready = r;
    Flush = f;
  endtask
  task automatic tick();
    @(posedge Clk);
    model_update();
    #1;
    check_model();
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", 64'(ov[0]), 0);
    chk("rst_ctrl", 64'(oc[0]), 0);
    chk("rst_data", 64'(od[0]), 0);
    chk("rst_occ", 64'(occ[0]), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    chk("rdy_after_rst", 64'(ir[0]), 1);
    tbl[0]  = '{1, 16'h0005, 32'hA000_000A, 1, 0, 1, 16'h0005, 32'hA000_000A, 2'd1, 1};
    tbl[1]  = '{1, 16'h0009, 32'hB000_000B, 1, 0, 1, 16'h0009, 32'hB000_000B, 2'd1, 1};
    tbl[2]  = '{0, 16'h0000, 32'h0,         1, 0, 0, 16'h0000, 32'hB000_000B, 2'd0, 1};
    tbl[3]  = '{1, 16'h0001, 32'hA1,        0, 0, 1, 16'h0001, 32'hA1,        2'd1, 1};
    tbl[4]  = '{1, 16'h0002, 32'hB1,        0, 0, 1, 16'h0001, 32'hA1,        2'd2, 0};
    tbl[5]  = '{1, 16'h0003, 32'hC1,        0, 0, 1, 16'h0001, 32'hA1,        2'd2, 0};
    tbl[6]  = '{1, 16'h0003, 32'hC1,        1, 0, 1, 16'h0002, 32'hB1,        2'd1, 1};
    tbl[7]  = '{1, 16'h0003, 32'hC1,        1, 0, 1, 16'h0003, 32'hC1,        2'd1, 1};
    tbl[8]  = '{0, 16'h0000, 32'h0,         1, 0, 0, 16'h0000, 32'hC1,        2'd0, 1};
    tbl[9]  = '{1, 16'h0004, 32'hD0,        0, 0, 1, 16'h0004, 32'hD0,        2'd1, 1};
    tbl[10] = '{1, 16'h0005, 32'hE0,        0, 0, 1, 16'h0004, 32'hD0,        2'd2, 0};
    tbl[11] = '{1, 16'h0006, 32'hF0,        0, 1, 0, 16'h0000, 32'hD0,        2'd0, 1};
    tbl[12] = '{0, 16'h0000, 32'h0,         1, 0, 0, 16'h0000, 32'hD0,        2'd0, 1};
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].f);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(ov[0]), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_ctrl", i), 64'(oc[0]), 64'(tbl[i].ec));
      chk($sformatf("vec%0d_data", i), 64'(od[0]), 64'(tbl[i].ed));
      chk($sformatf("vec%0d_occ", i), 64'(occ[0]), 64'(tbl[i].eocc));
      chk($sformatf("vec%0d_inrdy", i), 64'(ir[0]), 64'(tbl[i].eir));
    end
    drive(0, 0, 0, 1, 1);
    tick();
    drive(1, 16'h0007, 32'h77, 0, 0);
    tick();
    @(negedge Clk);
    In_Ctrl = 16'h0008;
    In_Data = 32'h88;
    #1;
    chk("noskid_stall_rdy", 64'(ir[1]), 0);
    Out_Ready = 1'b1;
    #1;
    chk("noskid_comb_rdy", 64'(ir[1]), 1);
    tick();
    chk("noskid_replace_ctrl", 64'(oc[1]), 16'h0008);
    chk("noskid_replace_data", 64'(od[1]), 32'h88);
    drive(0, 0, 0, 1, 1);
    tick();
    drive(1, 16'h0011, 32'h1111, 0, 0);
    tick();
    drive(1, 16'h0012, 32'h2222, 0, 0);
    tick();
    chk("clr_full_occ", 64'(occ[2]), 2);
    drive(1, 16'h0013, 32'h3333, 0, 1);
    tick();
    chk("clr_flush_valid", 64'(ov[2]), 0);
    chk("clr_flush_ctrl", 64'(oc[2]), 0);
    chk("clr_flush_data", 64'(od[2]), 0);
    chk("stale_flush_data", 64'(od[0]), 32'h1111);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("flushed_not_issued", 64'(ov[2]), 0);
    drive(1, 16'h0021, 32'h4444, 0, 0);
    tick();
    drive(1, 16'h0022, 32'h5555, 0, 0);
    tick();
    chk("pre_reset_occ", 64'(occ[0]), 2);
    @(negedge Clk);
    In_Valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid", 64'(ov[0]), 0);
    chk("async_ctrl", 64'(oc[0]), 0);
    chk("async_data", 64'(od[0]), 0);
    chk("async_occ", 64'(occ[0]), 0);
    check_model();
    tick();
    @(negedge Clk);
    Reset_n = 1'b1;
    Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_after_reset", 64'(ov[0]), 0);
    end
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom % 4 != 0), CW'($urandom), DW'($urandom), 1'($urandom % 3 != 0), 1'($urandom % 20 == 0));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
